fifo_drain_sequencer: RTL
=========================

# fifo_drain_sequencer

Read-side consumer for the asynchronous FIFO on the demo board. It pops one word per request, either a single-step key pulse or auto-drain, and presents the word on the LED bar and two 7-segment nibbles. After each pop it holds the display for a fixed dwell time so a human can read it. It runs entirely in the FIFO read-clock domain and drives the FIFO `en_rd` input directly.

## Interface
Parameters:
- `DATA_WIDTH`, 8 — FIFO word width; must be 8 (LED bar and two hex nibbles).
- `DWELL_CYCLES`, 3_600_000 — clk cycles the display is held after a pop (300 ms at 12 MHz); minimum 2.
- `CNT_WIDTH`, 8 — width of the popped-word counter.

Ports:
- `clk` in 1 — read-domain clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `step` in 1 — single-cycle pulse (debounced key) requesting one pop.
- `auto` in 1 — level; while high, pop continuously with dwell between pops.
- `clear` in 1 — single-cycle pulse; synchronous clear of counter, underflow flag and display.
- `empty` in 1 — FIFO empty flag, already synchronised to clk.
- `rd_data` in DATA_WIDTH — FIFO output word, valid the cycle after `rd_en`.
- `rd_en` out 1 — registered pop strobe to FIFO, exactly one cycle wide.
- `disp_data` out DATA_WIDTH — word currently shown.
- `seg_hi`, `seg_lo` out 4 — `disp_data[7:4]`, `disp_data[3:0]`.
- `busy` out 1 — high in any state other than IDLE.
- `underflow` out 1 — sticky; a `step` arrived while `empty` was high in IDLE.
- `pop_count` out CNT_WIDTH — number of words captured since reset/clear, wraps.

## Operation
- FSM: IDLE → READ → CAPTURE → DWELL → IDLE.
- IDLE: if `(step || auto) && !empty`, go to READ. If `step && empty`, set `underflow` and stay in IDLE. `auto` with `empty` waits silently.
- READ (1 cycle): `rd_en`=1. Always go to CAPTURE.
- CAPTURE (1 cycle): latch `rd_data` into `disp_data`, `pop_count`+1 (mod 2^CNT_WIDTH), load dwell counter with `DWELL_CYCLES-1`, go to DWELL.
- DWELL: decrement; at 0 return to IDLE. `step` is ignored in READ, CAPTURE and DWELL. It is not queued.
- `clear` in any state: `pop_count`=0, `underflow`=0, `disp_data`=0. FSM state is unaffected. `clear` takes priority over a same-cycle CAPTURE, so the count stays 0 and the display stays 0 (the popped word is discarded).
- `auto` deasserted mid-DWELL: the dwell completes, then the FSM idles.
- `empty` is only sampled in IDLE. `rd_en` is never asserted while `empty` was high on the deciding edge.
- `seg_hi`/`seg_lo` are combinational slices of `disp_data`.

## Timing
- Reset (async, rst=0): state IDLE, `rd_en`=0, `disp_data`=0, `pop_count`=0, `underflow`=0, `busy`=0, dwell counter 0. A reset in the middle of an operation aborts it immediately; no `rd_en` glitch.
- `step` sampled high at edge N (IDLE, !empty): `rd_en` high in cycle N+1. `rd_data` is captured at edge N+2. `disp_data`/`pop_count` are updated after edge N+2.
- `busy` rises after edge N and falls after the edge on which the dwell counter reaches 0. Total busy time is `DWELL_CYCLES+2` cycles.
- Auto back-to-back pop spacing: `DWELL_CYCLES+3` cycles between `rd_en` pulses (includes one IDLE cycle).
- `underflow` sets after the edge sampling `step && empty`.

## Configuration
- Macro: `DRAIN_BLANK_ON_EMPTY_EN`.
- Defined: on return to IDLE with `empty`=1, `disp_data` is cleared to 0 on that edge, so the display goes blank once the FIFO is drained.
- Undefined: `disp_data` holds the last captured word indefinitely. This is the default build.

## Test plan
- Reset, then preload FIFO with 0xA5. Pulse `step` → one `rd_en` pulse 1 cycle later; `disp_data`=0xA5, `seg_hi`=0xA, `seg_lo`=0x5, `pop_count`=1; `busy` high for `DWELL_CYCLES+2` cycles (use DWELL_CYCLES=4).
- FIFO empty, pulse `step` → no `rd_en`, `underflow`=1; then pulse `clear` → `underflow`=0.
- Preload 0x01,0x02,0x03, hold `auto` high → exactly 3 `rd_en` pulses spaced `DWELL_CYCLES+3` apart; `pop_count`=3; no further `rd_en` once `empty` is high.
- Second `step` pulse during DWELL → ignored; `pop_count` unchanged, single `rd_en`.
- Assert `rst` low one cycle after `rd_en` → all outputs zero immediately, state IDLE; after release, `step` pops the next word normally.
- With `DRAIN_BLANK_ON_EMPTY_EN` defined, pop last word 0x3C → `disp_data`=0x3C during dwell, then 0 in IDLE; without the macro it stays 0x3C.

Source files
------------

// File: rtl/fifo_drain_sequencer.sv
// Pops one FIFO word per step/auto request. rd_en goes high one cycle after the request and the word is shown two cycles after it, then held for DWELL_CYCLES.
// Requests arriving while busy are dropped, not queued. With DRAIN_BLANK_ON_EMPTY_EN defined, the display is blanked once the FIFO has drained.
module fifo_drain_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DWELL_CYCLES = 3_600_000,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  auto,
  input  logic                  clear,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic [3:0]            seg_hi,
  output logic [3:0]            seg_lo,
  output logic                  busy,
  output logic                  underflow,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  localparam int DCW = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, DWELL} state_t;

  state_t         state, state_nxt;
  logic [DCW-1:0] dwell_cnt, dwell_nxt;
  logic           underflow_set;

  always_comb begin
    state_nxt     = state;
    dwell_nxt     = dwell_cnt;
    underflow_set = 1'b0;
    case (state)
      IDLE: begin
        if ((step || auto) && !empty) state_nxt = READ;
        if (step && empty) underflow_set = 1'b1;
      end
      READ:    state_nxt = CAPTURE;
      CAPTURE: begin
        state_nxt = DWELL;
        dwell_nxt = DCW'(DWELL_CYCLES - 1);
      end
      DWELL: begin
        if (dwell_cnt == '0) state_nxt = IDLE;
        else dwell_nxt = dwell_cnt - DCW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rd_en is decoded from the next state so it leaves a flop, never glitches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      rd_en     <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      rd_en     <= (state_nxt == READ);
    end
  end

  // clear beats a same-cycle capture: the popped word is discarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_data <= '0;
      pop_count <= '0;
      underflow <= 1'b0;
    end else if (clear) begin
      disp_data <= '0;
      pop_count <= '0;
      underflow <= 1'b0;
    end else begin
      if (underflow_set) underflow <= 1'b1;
      if (state == CAPTURE) begin
        disp_data <= rd_data;
        pop_count <= pop_count + CNT_WIDTH'(1);
      end
`ifdef DRAIN_BLANK_ON_EMPTY_EN
      else if (state == DWELL && dwell_cnt == '0 && empty) begin
        disp_data <= '0;
      end
`endif
    end
  end

  assign busy   = (state != IDLE);
  assign seg_hi = disp_data[7:4];
  assign seg_lo = disp_data[3:0];

endmodule
